// File: rtl/dfe_out_pkg.sv
// rtl/dfe_out_pkg.sv - shared types and constants for the DFE output buffer
package dfe_out_pkg;

  localparam int DFE_OUT_DATA_WIDTH = 16;
  localparam int DFE_OUT_DEPTH_DEF  = 16;
  localparam int DFE_OUT_LVL_W_DEF  = 5;

  typedef struct packed {
    logic                                 ovf;
    logic                                 unf;
    logic signed [DFE_OUT_DATA_WIDTH-1:0] data;
  } dfe_sample_t;

endpackage

// File: rtl/dfe_out_fifo_mem.sv
// rtl/dfe_out_fifo_mem.sv - DEPTH x dfe_sample_t storage, sync write, async read
module dfe_out_fifo_mem
  import dfe_out_pkg::*;
#(
  parameter int DEPTH  = DFE_OUT_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  dfe_sample_t       wr_data,
  input  logic [ADDR_W-1:0] rd_ptr,
  output dfe_sample_t       rd_data
);

  dfe_sample_t mem [DEPTH];

  // Storage is deliberately unreset; validity is tracked by the level counter.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/dfe_out_buffer.sv
// rtl/dfe_out_buffer.sv - FWFT elastic output FIFO after the DFE core; DFE_OUT_STATS_EN adds ovf/unf counters
module dfe_out_buffer
  import dfe_out_pkg::*;
#(
  parameter int DATA_WIDTH = DFE_OUT_DATA_WIDTH,
  parameter int DEPTH      = DFE_OUT_DEPTH_DEF,
  parameter int AF_THRESH  = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       ovf_in,
  input  logic                       unf_in,
  input  logic                       flush,
  input  logic                       clr_sticky,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_ovf,
  output logic                       m_unf,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       drop_sticky,
  output logic [CNT_WIDTH-1:0]       ovf_count,
  output logic [CNT_WIDTH-1:0]       unf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic             full, pop, push, drop;
  dfe_sample_t      wr_data, rd_data;

  assign m_valid = (level != '0);
  assign full    = (level == LVL_W'(DEPTH));
  // flush overrides every other action in its cycle, including drop detection
  assign pop     = m_valid & m_ready & ~flush;
  assign push    = valid_in & (~full | pop) & ~flush;
  assign drop    = valid_in & full & ~pop & ~flush;

  always_comb begin
    level_nxt = level;
    if (flush)             level_nxt = '0;
    else if (push && !pop) level_nxt = level + 1'b1;
    else if (pop && !push) level_nxt = level - 1'b1;
  end

  assign wr_data.ovf  = ovf_in;
  assign wr_data.unf  = unf_in;
  assign wr_data.data = DFE_OUT_DATA_WIDTH'(data_in);

  dfe_out_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  // Gate the head so outputs read zero whenever the FIFO is empty.
  assign m_data = m_valid ? DATA_WIDTH'(rd_data.data) : '0;
  assign m_ovf  = m_valid & rd_data.ovf;
  assign m_unf  = m_valid & rd_data.unf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      almost_full <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      level       <= level_nxt;
      almost_full <= (level_nxt >= LVL_W'(AF_THRESH));
      if (drop)            drop_sticky <= 1'b1;
      else if (clr_sticky) drop_sticky <= 1'b0;
    end
  end

`ifdef DFE_OUT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
      unf_count <= '0;
    end else begin
      if (push && ovf_in) begin
        if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
      end else if (clr_sticky) begin
        ovf_count <= '0;
      end
      if (push && unf_in) begin
        if (unf_count != '1) unf_count <= unf_count + 1'b1;
      end else if (clr_sticky) begin
        unf_count <= '0;
      end
    end
  end
`else
  assign ovf_count = '0;
  assign unf_count = '0;
`endif

endmodule
